// File: rtl/cmul_pipe.sv
// Three-stage flow-controlled fixed-point complex multiplier (a+jb)*(c+/-jd)
// with selectable round-half-up and saturate/wrap on the narrowed result.
module cmul_pipe #(
   parameter int WIDTH = 16,
   parameter int FRAC  = WIDTH-1,
   parameter int ROUND = 1,
   parameter int SAT   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] real_in,
   input  logic [WIDTH-1:0] complex_in,
   input  logic [WIDTH-1:0] twiddle_real,
   input  logic [WIDTH-1:0] twiddle_complex,
   input  logic             conj_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] R_out,
   output logic [WIDTH-1:0] C_out,
   output logic             ovf_out
);

   localparam int PW = 2*WIDTH+1;
   localparam int SW = 2*WIDTH+2;
   localparam logic [SW-1:0] RND = (ROUND != 0) ? (SW'(1) << (FRAC-1)) : '0;

   // {ovf, value}: ovf when the bits above the kept field are not a sign extension
   function automatic logic [WIDTH:0] fit(input logic [SW-1:0] v);
      logic             ovf;
      logic [WIDTH-1:0] res;
      ovf = !((&v[SW-1:WIDTH-1]) | ~(|v[SW-1:WIDTH-1]));
      res = v[WIDTH-1:0];
      if ((SAT != 0) && ovf)
         res = v[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      return {ovf, res};
   endfunction

   logic                    r_v1, r_v2, r_ov;
   logic [WIDTH-1:0]        r_a, r_b, r_c;
   logic [WIDTH:0]          r_d;
   logic signed [PW-1:0]    r_ac, r_bd, r_ad, r_bc;
   logic [WIDTH-1:0]        r_re, r_im;
   logic                    r_ovf;

   logic                    w_ld1, w_ld2, w_ld3;
   logic signed [WIDTH:0]   w_dx, w_dn;
   logic signed [PW-1:0]    w_ax, w_bx, w_cx, w_dpx;
   logic signed [SW-1:0]    w_p, w_q, w_ps, w_qs;
   logic [WIDTH:0]          w_fr, w_fi;

   // A stage may take new data when empty or when its contents move on.
   assign w_ld3    = !r_ov | out_ready;
   assign w_ld2    = !r_v2 | w_ld3;
   assign w_ld1    = !r_v1 | w_ld2;
   assign in_ready = w_ld1;

   // WIDTH+1 bits so that negating the most negative d stays exact
   assign w_dx = {twiddle_complex[WIDTH-1], twiddle_complex};
   assign w_dn = conj_in ? -w_dx : w_dx;

   assign w_ax  = {{(PW-WIDTH){r_a[WIDTH-1]}}, r_a};
   assign w_bx  = {{(PW-WIDTH){r_b[WIDTH-1]}}, r_b};
   assign w_cx  = {{(PW-WIDTH){r_c[WIDTH-1]}}, r_c};
   assign w_dpx = {{(PW-WIDTH-1){r_d[WIDTH]}}, r_d};

   assign w_p  = {r_ac[PW-1], r_ac} - {r_bd[PW-1], r_bd} + RND;
   assign w_q  = {r_ad[PW-1], r_ad} + {r_bc[PW-1], r_bc} + RND;
   assign w_ps = w_p >>> FRAC;
   assign w_qs = w_q >>> FRAC;
   assign w_fr = fit(w_ps);
   assign w_fi = fit(w_qs);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1 <= 1'b0;
         r_a  <= '0;
         r_b  <= '0;
         r_c  <= '0;
         r_d  <= '0;
      end else if (w_ld1) begin
         r_v1 <= in_valid;
         if (in_valid) begin
            r_a <= real_in;
            r_b <= complex_in;
            r_c <= twiddle_real;
            r_d <= w_dn;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v2 <= 1'b0;
         r_ac <= '0;
         r_bd <= '0;
         r_ad <= '0;
         r_bc <= '0;
      end else if (w_ld2) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_ac <= w_ax * w_cx;
            r_bd <= w_bx * w_dpx;
            r_ad <= w_ax * w_dpx;
            r_bc <= w_bx * w_cx;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ov  <= 1'b0;
         r_re  <= '0;
         r_im  <= '0;
         r_ovf <= 1'b0;
      end else if (w_ld3) begin
         r_ov <= r_v2;
         if (r_v2) begin
            r_re  <= w_fr[WIDTH-1:0];
            r_im  <= w_fi[WIDTH-1:0];
            r_ovf <= w_fr[WIDTH] | w_fi[WIDTH];
         end
      end
   end

   assign out_valid = r_ov;
   assign R_out     = r_re;
   assign C_out     = r_im;
   assign ovf_out   = r_ovf;

endmodule
